// File: rtl/sram_sc_pkg.sv
// Shared types for the two-requester SRAM arbiter: grant FSM states and the
// requester id carried in the pending-read tag FIFO.
package sram_sc_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  // Grant state that belongs to a given requester id.
  function automatic arb_state_t own_state(input req_id_t id);
    return (id == 1'b1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/sram_sc_tag_fifo.sv
// Pending-read tag FIFO: remembers which requester issued each outstanding
// read so returning data can be steered without added latency.
module sram_sc_tag_fifo
  import sram_sc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  req_id_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Tag storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_id;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so readdatavalid can be steered the same cycle.
  assign head_id = mem[rd_ptr_reg];
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/sram_sc_arbiter.sv
// Shares one pipelined Avalon-MM SRAM slave between two Avalon-MM requesters.
// Alternating round-robin grant, combinational command forwarding, and a tag
// FIFO that routes read data back to whoever issued the read.
module sram_sc_arbiter
  import sram_sc_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_rdv
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_PEND) + 1;

  logic [ADDR_W-1:0]  m_address   [NUM_REQ];
  logic [DATA_W-1:0]  m_writedata [NUM_REQ];
  logic [BE_W-1:0]    m_byteenable[NUM_REQ];
  logic [NUM_REQ-1:0] m_read;
  logic [NUM_REQ-1:0] m_write;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] wait_vec;
  logic [NUM_REQ-1:0] rdv_vec;

  arb_state_t state_reg, state_next;
  req_id_t    last_grant_reg, last_grant_next;
  logic       err_rdv_reg;

  logic       grant_valid;
  req_id_t    grant_id;
  req_id_t    other_id;
  logic       read_block;
  logic       accept;
  logic       tag_push;
  logic       tag_pop;
  logic       stray_rdv;
  req_id_t    tag_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign m_address[0]    = m0_address;
  assign m_address[1]    = m1_address;
  assign m_writedata[0]  = m0_writedata;
  assign m_writedata[1]  = m1_writedata;
  assign m_byteenable[0] = m0_byteenable;
  assign m_byteenable[1] = m1_byteenable;
  assign m_read          = {m1_read, m0_read};
  assign m_write         = {m1_write, m0_write};
  assign req             = m_read | m_write;

  assign grant_valid = (state_reg == ST_OWN0) || (state_reg == ST_OWN1);
  assign grant_id    = req_id_t'(state_reg == ST_OWN1);
  assign other_id    = ~grant_id;

  // A granted read is held off while every tag slot is in use; writes still flow.
  assign read_block = grant_valid && m_read[grant_id] && fifo_full;
  assign accept     = grant_valid && req[grant_id] && !s_waitrequest && !read_block;
  assign tag_push   = accept && m_read[grant_id];
  assign tag_pop    = s_readdatavalid && !fifo_empty;
  assign stray_rdv  = s_readdatavalid && (fifo_count == '0);

  // Forward the granted requester's command straight to the slave.
  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    if (grant_valid) begin
      s_address    = m_address[grant_id];
      s_writedata  = m_writedata[grant_id];
      s_byteenable = m_byteenable[grant_id];
      s_read       = m_read[grant_id] && !fifo_full;
      s_write      = m_write[grant_id];
    end
  end

  // Grant next-state: tie goes to the requester that was not served last.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    if (!grant_valid) begin
      if (req[0] && req[1])
        state_next = (last_grant_reg == 1'b1) ? ST_OWN0 : ST_OWN1;
      else if (req[0])
        state_next = ST_OWN0;
      else if (req[1])
        state_next = ST_OWN1;
      else
        state_next = ST_IDLE;
    end else if (accept || !req[grant_id]) begin
      // A withdrawn request releases the grant so the other side cannot starve.
      if (accept) last_grant_next = grant_id;
      state_next = req[other_id] ? own_state(other_id) : ST_IDLE;
    end
  end

  // Grant state and last-served requester.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Sticky flag for read data that arrived with nothing outstanding.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) err_rdv_reg <= 1'b0;
    else if (stray_rdv) err_rdv_reg <= 1'b1;
  end

  sram_sc_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (tag_push),
    .push_id (grant_id),
    .pop     (tag_pop),
    .head_id (tag_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign wait_vec[gi] = !(grant_valid && (grant_id == req_id_t'(gi)))
                            || s_waitrequest || read_block;
      assign rdv_vec[gi]  = tag_pop && (tag_head == req_id_t'(gi));
    end
  endgenerate

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdatavalid = rdv_vec[0];
  assign m1_readdatavalid = rdv_vec[1];
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign err_rdv          = err_rdv_reg;

endmodule

// File: tb/tb_sram_sc_arbiter.sv
// Directed bench for sram_sc_arbiter with default parameters.
module tb_sram_sc_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic [31:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic        err_rdv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_clk = ~clk_clk;

  sram_sc_arbiter dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_waitrequest    (s_waitrequest),
    .s_readdata       (s_readdata),
    .s_readdatavalid  (s_readdatavalid),
    .err_rdv          (err_rdv)
  );

  task automatic tick;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("[%0t] check %s observed=0x%0h", $time, tag, obs);
  endtask

  task automatic idle_inputs;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #1 reset_reset_n = 1'b0;
    #1;
    // Reset state
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_err_rdv", err_rdv, 0);
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;

    // Both write in the same cycle: m0 wins the first tie, m1 follows.
    m0_write = 1; m0_address = 32'h100; m0_writedata = 32'h11111111; m0_byteenable = 4'hF;
    m1_write = 1; m1_address = 32'h200; m1_writedata = 32'h22222222; m1_byteenable = 4'h3;
    #1;
    chk("wr_idle_s_write", s_write, 0);
    chk("wr_idle_m0_wait", m0_waitrequest, 1);
    chk("wr_idle_m1_wait", m1_waitrequest, 1);
    tick();
    chk("wr0_s_write", s_write, 1);
    chk("wr0_s_address", s_address, 32'h100);
    chk("wr0_s_writedata", s_writedata, 32'h11111111);
    chk("wr0_m0_wait", m0_waitrequest, 0);
    chk("wr0_m1_wait", m1_waitrequest, 1);
    tick();
    m0_write = 0;
    #1;
    chk("wr1_s_write", s_write, 1);
    chk("wr1_s_address", s_address, 32'h200);
    chk("wr1_s_byteenable", s_byteenable, 4'h3);
    chk("wr1_m1_wait", m1_waitrequest, 0);
    chk("wr1_m0_wait", m0_waitrequest, 1);
    tick();
    m1_write = 0;
    #1;
    chk("wr_done_s_write", s_write, 0);

    // m0 reads 0x10, m1 reads 0x20, data steered back in order.
    m0_read = 1; m0_address = 32'h10;
    m1_read = 1; m1_address = 32'h20;
    tick();
    chk("rd0_s_read", s_read, 1);
    chk("rd0_s_address", s_address, 32'h10);
    tick();
    m0_read = 0;
    #1;
    chk("rd1_s_read", s_read, 1);
    chk("rd1_s_address", s_address, 32'h20);
    chk("rd1_m1_wait", m1_waitrequest, 0);
    tick();
    m1_read = 0;
    s_readdatavalid = 1; s_readdata = 32'hAAAA;
    #1;
    chk("rdA_m0_rdv", m0_readdatavalid, 1);
    chk("rdA_m1_rdv", m1_readdatavalid, 0);
    chk("rdA_m0_data", m0_readdata, 32'hAAAA);
    tick();
    s_readdata = 32'hBBBB;
    #1;
    chk("rdB_m1_rdv", m1_readdatavalid, 1);
    chk("rdB_m0_rdv", m0_readdatavalid, 0);
    chk("rdB_m1_data", m1_readdata, 32'hBBBB);
    tick();
    s_readdatavalid = 0;

    // m0 issues five reads with no data returned: fifth stalls until a tag frees.
    m0_read = 1; m0_address = 32'h40;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rd%0d_idle_m0_wait", i), m0_waitrequest, 1);
      tick();
      chk($sformatf("rd%0d_s_read", i), s_read, 1);
      chk($sformatf("rd%0d_m0_wait", i), m0_waitrequest, 0);
      tick();
    end
    tick();
    chk("full_s_read_a", s_read, 0);
    chk("full_m0_wait_a", m0_waitrequest, 1);
    tick();
    chk("full_s_read_b", s_read, 0);
    chk("full_m0_wait_b", m0_waitrequest, 1);
    s_readdatavalid = 1; s_readdata = 32'h1234;
    #1;
    chk("full_pop_m0_rdv", m0_readdatavalid, 1);
    chk("full_pop_s_read", s_read, 0);
    tick();
    s_readdatavalid = 0;
    #1;
    chk("rd5_s_read", s_read, 1);
    chk("rd5_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0;
    for (int i = 0; i < 4; i++) begin
      s_readdatavalid = 1; s_readdata = 32'h5000 + i;
      #1;
      chk($sformatf("drain%0d_m0_rdv", i), m0_readdatavalid, 1);
      chk($sformatf("drain%0d_m1_rdv", i), m1_readdatavalid, 0);
      tick();
    end
    s_readdatavalid = 0;

    // Slave stalls an m1 write for three cycles while m0 waits to read.
    m1_write = 1; m1_address = 32'h300; m1_writedata = 32'hCAFE; m1_byteenable = 4'hC;
    s_waitrequest = 1;
    tick();
    m0_read = 1; m0_address = 32'h50;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_s_write", i), s_write, 1);
      chk($sformatf("stall%0d_s_address", i), s_address, 32'h300);
      chk($sformatf("stall%0d_s_writedata", i), s_writedata, 32'hCAFE);
      chk($sformatf("stall%0d_m1_wait", i), m1_waitrequest, 1);
      chk($sformatf("stall%0d_m0_wait", i), m0_waitrequest, 1);
      tick();
    end
    s_waitrequest = 0;
    #1;
    chk("stall_end_m1_wait", m1_waitrequest, 0);
    chk("stall_end_s_address", s_address, 32'h300);
    tick();
    m1_write = 0;
    #1;
    chk("after_stall_s_read", s_read, 1);
    chk("after_stall_s_address", s_address, 32'h50);
    chk("after_stall_m0_wait", m0_waitrequest, 0);
    tick();
    m0_read = 0;
    s_readdatavalid = 1; s_readdata = 32'h5555;
    #1;
    chk("after_stall_m0_rdv", m0_readdatavalid, 1);
    tick();
    s_readdatavalid = 0;

    // Stray readdatavalid with nothing outstanding.
    s_readdatavalid = 1; s_readdata = 32'hDEAD;
    #1;
    chk("stray_m0_rdv", m0_readdatavalid, 0);
    chk("stray_m1_rdv", m1_readdatavalid, 0);
    chk("stray_err_pre", err_rdv, 0);
    tick();
    s_readdatavalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stray_err_hold%0d", i), err_rdv, 1);
      tick();
    end

    // Reset with two m0 reads outstanding and an m1 write in flight.
    m0_read = 1; m0_address = 32'h60;
    tick();
    tick();
    tick();
    tick();
    m1_write = 1; m1_address = 32'h70;
    tick();
    chk("pre_rst_s_write", s_write, 1);
    reset_reset_n = 0;
    s_readdatavalid = 1;
    #1;
    chk("mid_rst_s_read", s_read, 0);
    chk("mid_rst_s_write", s_write, 0);
    chk("mid_rst_m0_wait", m0_waitrequest, 1);
    chk("mid_rst_m1_wait", m1_waitrequest, 1);
    chk("mid_rst_m0_rdv", m0_readdatavalid, 0);
    chk("mid_rst_m1_rdv", m1_readdatavalid, 0);
    chk("mid_rst_err_rdv", err_rdv, 0);
    tick();
    idle_inputs();
    reset_reset_n = 1;
    #1;
    s_readdatavalid = 1; s_readdata = 32'h77;
    #1;
    chk("post_rst_m0_rdv", m0_readdatavalid, 0);
    chk("post_rst_m1_rdv", m1_readdatavalid, 0);
    tick();
    s_readdatavalid = 0;
    #1;
    chk("post_rst_err_rdv", err_rdv, 1);

    // Read and write together from one requester pass through unchanged.
    m1_read = 1; m1_write = 1; m1_address = 32'h80; m1_writedata = 32'h9;
    tick();
    chk("rw_s_read", s_read, 1);
    chk("rw_s_write", s_write, 1);
    chk("rw_s_address", s_address, 32'h80);
    tick();
    m1_read = 0; m1_write = 0;
    s_readdatavalid = 1; s_readdata = 32'h99;
    #1;
    chk("rw_m1_rdv", m1_readdatavalid, 1);
    chk("rw_m0_rdv", m0_readdatavalid, 0);
    tick();
    s_readdatavalid = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_sc_arbiter.md
SRAM_SC_ARBITER -- requirements
Module: sram_sc_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width (byteenable width DATA_W/8); MAX_PEND, default 4, maximum outstanding reads (power of two).
REQ-002 SHALL have ports:
clk_clk  in  1  single clock, all logic rising-edge
reset_reset_n  in  1  asynchronous active-low reset
mN_address  in  ADDR_W  requester N address (N = 0,1)
mN_read / mN_write  in  1  requester N commands
mN_writedata  in  DATA_W  requester N write data
mN_byteenable  in  DATA_W/8  requester N byte enables
mN_waitrequest  out  1  stall to requester N
mN_readdata  out  DATA_W  read data to requester N
mN_readdatavalid  out  1  read data valid to requester N
s_address  out  ADDR_W  to SRAM slave
s_read / s_write  out  1  to SRAM slave
s_writedata  out  DATA_W  to SRAM slave
s_byteenable  out  DATA_W/8  to SRAM slave
s_waitrequest  in  1  from SRAM slave
s_readdata  in  DATA_W  from SRAM slave
s_readdatavalid  in  1  from SRAM slave
err_rdv  out  1  sticky: readdatavalid with no read pending

Function
REQ-003 SHALL share one pipelined Avalon-MM SRAM slave between two Avalon-MM requesters (mN_read|mN_write = request).
REQ-004 SHALL use FSM IDLE, OWN0, OWN1; grant state registered.
REQ-005 IDLE: one request -> OWN of that requester; both -> OWN of requester not in last_grant; none -> IDLE.
REQ-006 OWNx: granted command (address, read, write, writedata, byteenable) SHALL be forwarded combinationally to s_*; mx_waitrequest = s_waitrequest or read block (REQ-009).
REQ-007 OWNx, on acceptance (command asserted, s_waitrequest=0, not blocked): last_grant<=x; other requester requesting -> OWN other, else -> IDLE.
REQ-008 Non-granted requester and IDLE SHALL see mN_waitrequest=1; s_read=s_write=0 in IDLE.
REQ-009 Pending-read tag FIFO, depth MAX_PEND: push requester id on accepted read; pop on s_readdatavalid. FIFO full -> s_read forced 0 and granted reader stalled; writes unaffected.
REQ-010 Simultaneous push and pop SHALL be legal at any occupancy except push while full (prevented by REQ-009); count unchanged.
REQ-011 s_readdata SHALL drive both mN_readdata; mN_readdatavalid = s_readdatavalid and FIFO head == N, same cycle (zero added latency).
REQ-012 s_readdatavalid with FIFO empty SHALL be dropped (no mN_readdatavalid) and set err_rdv until reset.
REQ-013 Command latency: request from IDLE reaches s_* one cycle later; back-to-back alternating requests SHALL sustain one accepted command per cycle.
REQ-014 Simultaneous read and write from one requester SHALL be forwarded unchanged (illegal per Avalon, not checked).

Reset
REQ-015 Asynchronous assert, on reset_reset_n low: FSM IDLE, last_grant=1 (requester 0 wins first tie), FIFO empty, err_rdv=0.
REQ-016 Outputs during reset: s_read=s_write=0, mN_waitrequest=1, mN_readdatavalid=0.
REQ-017 Reset mid-transfer SHALL discard outstanding tags; later stray s_readdatavalid handled per REQ-012.

Structure
REQ-018 FSM state enum and requester-id type SHALL live in shared package sram_sc_pkg.
REQ-019 Tag FIFO SHALL be sub-module sram_sc_tag_fifo (1-bit data, MAX_PEND deep, full/empty/count).

Verification
REQ-020 Both write same cycle from reset, s_waitrequest=0 -> m0 accepted first, m1 next cycle, m1_waitrequest=1 in between.
REQ-021 m0 reads 0x10, m1 reads 0x20, slave returns 0xAAAA then 0xBBBB -> m0_readdatavalid with 0xAAAA, then m1_readdatavalid with 0xBBBB.
REQ-022 m0 issues 5 reads, slave withholds data -> 4 accepted, 5th stalled (s_read=0) until first readdatavalid, then accepted.
REQ-023 s_waitrequest=1 for 3 cycles during m1 write -> s_* stable, m1_waitrequest=1, grant held on m1 despite m0 request.
REQ-024 s_readdatavalid with no reads outstanding -> no mN_readdatavalid, err_rdv=1 held until reset.
REQ-025 reset_reset_n low with 2 reads pending -> all outputs per REQ-016 immediately, FIFO empty after release.
